dp_result_checker: RTL and testbench
====================================

// Module: dp_result_checker
// PURPOSE
//  Hardware result checker at the output end of the dp_pipe datapath. Accepts the golden answer
//  for each vector issued into dp_pipe, delays it to match pipeline latency, compares it with
//  dp_pipe's result, and reports pass/fail statistics plus the first failing vector.
//  Enables on-chip and emulation regression with no file dump of results.
// PARAMETERS
//  LATENCY  4   cycles from dp_pipe input sample to valid result (>=1)
//  DEPTH    8   golden FIFO entries, power of 2, >= LATENCY+1
//  ULP_TOL  0   allowed magnitude difference in ULPs (0 = bit-exact)
//  CNT_W    16  width of vector counters
// PORTS
//  clk            in   1      system clock
//  rst            in   1      asynchronous reset, active-low
//  start          in   1      pulse: begin run of num_vec vectors
//  num_vec        in   CNT_W  vectors in run, sampled with start
//  in_valid       in   1      vector driven into dp_pipe this cycle
//  exp_data       in   32     golden answer for that vector
//  result         in   32     dp_pipe result
//  busy           out  1      run in progress
//  done           out  1      one-cycle pulse at run end
//  checked_cnt    out  CNT_W  results compared
//  mismatch_cnt   out  CNT_W  results failing compare (saturating)
//  first_err_idx  out  CNT_W  index of first failing vector
//  first_err_got  out  32     result of first failure
//  first_err_exp  out  32     golden of first failure
//  ovf            out  1      sticky: push attempted into full FIFO
// BEHAVIOUR
//  - Reset: state IDLE; FIFO and pointers cleared; valid shift register 0; all outputs 0.
//  - FSM: IDLE -start-> RUN (clears counters, first_err_*, ovf; latches num_vec; issued=0).
//    num_vec==0: IDLE -start-> DONE. RUN -issued==num_vec-> DRAIN.
//    DRAIN -checked_cnt==num_vec-> DONE. DONE -> IDLE unconditionally; done=1 only in DONE.
//    busy=1 in RUN and DRAIN. start outside IDLE is ignored.
//  - Push: in_valid in RUN with issued<num_vec writes exp_data to FIFO, issued++, and shifts 1 into
//    the LATENCY-deep valid shift register. Otherwise 0 is shifted in; in_valid is ignored.
//  - Compare: when shift register output is 1 (push at edge t -> compare at edge t+LATENCY), pop
//    FIFO head and compare with result in that cycle. Counters update on that edge.
//  - Match rule: bit-equal; or both zero (+0 == -0); or both NaN (exp all ones, mantissa!=0);
//    or same sign, neither NaN/Inf, |mag_res - mag_exp| <= ULP_TOL on 31-bit magnitude field.
//  - Mismatch: mismatch_cnt++ (saturates at all ones); if first mismatch of run, capture
//    first_err_idx=checked_cnt (pre-increment), first_err_got, first_err_exp. Later fails don't overwrite.
//  - FIFO full with push and pop in same cycle: legal, no ovf. Push when full without pop: data dropped,
//    ovf=1, and the matching compare counts as mismatch with first_err_exp=0.
//  - Pop from empty FIFO cannot occur by construction. Verification asserts this.
//  - Reset mid-run: immediate return to IDLE, all state lost, no done pulse.
//  - Counters and first_err_* hold after DONE until the next start.
// CONFIGURATION
//  DP_CHK_HALF_EN defined: extra port calc_mode in 1 (1=single, 0=half), sampled with start.
//    Half mode compares result[15:0] vs exp_data[15:0] with FP16 zero/NaN rules (5-bit exponent),
//    ULP check on the 15-bit magnitude. first_err_got/exp report full 32 bits.
//  DP_CHK_HALF_EN undefined: no calc_mode port; single-precision compare only.
// TESTING
//  1 num_vec=4, golden==result for all, LATENCY=4 -> done 1 cycle after 4th compare,
//    checked=4, mismatch=0.
//  2 num_vec=3, vector 1 result 0x3F800001 vs exp 0x3F800000, ULP_TOL=0
//    -> mismatch=1, first_err_idx=1, got=0x3F800001, exp=0x3F800000.
//  3 Same as 2 with ULP_TOL=1 -> mismatch=0. Result 0x80000000 vs exp 0x00000000 -> match.
//    0x7FC00000 vs 0x7FC00001 -> match.
//  4 num_vec=0 start -> done pulses next cycle, busy never 1. in_valid with busy=0 -> no counter change.
//  5 DEPTH=4, LATENCY=4, 4 back-to-back valids -> no ovf.
//    Force FIFO full with no pop (shift register held) -> ovf=1, sticky until next start.
//  6 rst low at 2nd of 6 vectors -> outputs 0 asynchronously. New start num_vec=2 runs clean, mismatch=0.
//    With DP_CHK_HALF_EN, calc_mode=0, result 0xABCD3C00 vs exp 0x00003C00 -> match.

Source files
------------

// File: rtl/dp_result_checker.sv
// Delays golden answers by LATENCY cycles through a FIFO and compares them with dp_pipe results; no backpressure,
// overflowed entries are dropped and reported as mismatches. `define DP_CHK_HALF_EN adds calc_mode for FP16 compares.
module dp_result_checker #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8,
  parameter int ULP_TOL = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
`ifdef DP_CHK_HALF_EN
  input  logic             calc_mode,
`endif
  input  logic             in_valid,
  input  logic [31:0]      exp_data,
  input  logic [31:0]      result,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] checked_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [31:0]      first_err_got,
  output logic [31:0]      first_err_exp,
  output logic             ovf
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]   num_lat, issued;
  logic [31:0]        mem [DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic [LATENCY-1:0] vld_sr, drop_sr;
  logic               half;
  logic               push_req, push, drop, pop, pop_drop, pop_fifo;
  logic               fifo_full, fifo_empty, match;
  logic [31:0]        head, cmp_exp;

  function automatic logic fp_match(input logic [31:0] r, input logic [31:0] e, input logic hm);
    logic [30:0] mr, me, diff;
    logic        sr, se, spc_r, spc_e, nan_r, nan_e;
    if (hm) begin
      mr = {16'd0, r[14:0]};  me = {16'd0, e[14:0]};
      sr = r[15];             se = e[15];
      spc_r = &r[14:10];      spc_e = &e[14:10];
      nan_r = spc_r && (|r[9:0]);
      nan_e = spc_e && (|e[9:0]);
    end else begin
      mr = r[30:0];           me = e[30:0];
      sr = r[31];             se = e[31];
      spc_r = &r[30:23];      spc_e = &e[30:23];
      nan_r = spc_r && (|r[22:0]);
      nan_e = spc_e && (|e[22:0]);
    end
    diff = (mr >= me) ? (mr - me) : (me - mr);
    fp_match = (mr == me && sr == se) || (mr == '0 && me == '0) || (nan_r && nan_e) ||
               (sr == se && !spc_r && !spc_e && {1'b0, diff} <= 32'(ULP_TOL));
  endfunction

`ifdef DP_CHK_HALF_EN
  logic half_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) half_q <= 1'b0;
    else if (state == IDLE && start) half_q <= ~calc_mode;
  end
  assign half = half_q;
`else
  assign half = 1'b0;
`endif

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head       = mem[rd_ptr[AW-1:0]];

  // A dropped golden never reached the FIFO, so its compare must not pop
  assign pop      = vld_sr[LATENCY-1];
  assign pop_drop = drop_sr[LATENCY-1];
  assign pop_fifo = pop && !pop_drop;
  assign push_req = (state == RUN) && in_valid && (issued < num_lat);
  assign push     = push_req && (!fifo_full || pop_fifo);
  assign drop     = push_req && !push;
  assign cmp_exp  = pop_drop ? 32'd0 : head;
  assign match    = !pop_drop && fp_match(result, head, half);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_vec == '0) ? DONE : RUN;
      RUN:     if (issued == num_lat) state_nxt = DRAIN;
      DRAIN:   if (checked_cnt == num_lat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= exp_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      num_lat       <= '0;
      issued        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      vld_sr        <= '0;
      drop_sr       <= '0;
      checked_cnt   <= '0;
      mismatch_cnt  <= '0;
      first_err_idx <= '0;
      first_err_got <= '0;
      first_err_exp <= '0;
      ovf           <= 1'b0;
    end else begin
      state   <= state_nxt;
      vld_sr  <= (vld_sr << 1) | LATENCY'(push_req);
      drop_sr <= (drop_sr << 1) | LATENCY'(drop);
      if (push)     wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_fifo) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_req) issued <= issued + CNT_W'(1);
      if (drop)     ovf    <= 1'b1;
      if (state == IDLE && start) begin
        num_lat       <= num_vec;
        issued        <= '0;
        checked_cnt   <= '0;
        mismatch_cnt  <= '0;
        first_err_idx <= '0;
        first_err_got <= '0;
        first_err_exp <= '0;
        ovf           <= 1'b0;
      end else if (pop) begin
        checked_cnt <= checked_cnt + CNT_W'(1);
        if (!match) begin
          if (~&mismatch_cnt) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
          if (mismatch_cnt == '0) begin
            first_err_idx <= checked_cnt;
            first_err_got <= result;
            first_err_exp <= cmp_exp;
          end
        end
      end
    end
  end

`ifndef SYNTHESIS
  pop_from_empty: assert property (@(posedge clk) disable iff (!rst) !(pop_fifo && fifo_empty));
`endif
endmodule

// File: tb/tb_dp_result_checker.sv
// Directed bench: four checker instances (default, ULP_TOL=1, DEPTH=4, DEPTH=2) share one stimulus stream.
module tb_dp_result_checker;
  logic        clk, rst, start, in_valid;
  logic [15:0] num_vec;
  logic [31:0] exp_data, drv_res, result;
`ifdef DP_CHK_HALF_EN
  logic        calc_mode;
`endif
  logic        busy_o [4], done_o [4], ovf_o [4];
  logic [15:0] chk [4], mis [4], fidx [4];
  logic [31:0] fgot [4], fexp [4];
  logic [31:0] pipe [4];
  logic [31:0] v_exp [8], v_res [8];
  int          checks = 0, failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for dp_pipe: result appears LATENCY=4 edges after the vector is sampled
  always @(posedge clk) begin
    pipe[0] <= drv_res;
    for (int i = 3; i > 0; i--) pipe[i] <= pipe[i-1];
  end
  assign result = pipe[3];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dp_result_checker #(
      .LATENCY(4), .DEPTH(g == 2 ? 4 : (g == 3 ? 2 : 8)), .ULP_TOL(g == 1 ? 1 : 0), .CNT_W(16)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
`ifdef DP_CHK_HALF_EN
      .calc_mode(calc_mode),
`endif
      .in_valid(in_valid), .exp_data(exp_data), .result(result),
      .busy(busy_o[g]), .done(done_o[g]), .checked_cnt(chk[g]), .mismatch_cnt(mis[g]),
      .first_err_idx(fidx[g]), .first_err_got(fgot[g]), .first_err_exp(fexp[g]), .ovf(ovf_o[g])
    );
  end

  task automatic start_run(input int n);
    @(negedge clk); start = 1'b1; num_vec = 16'(n);
    @(negedge clk); start = 1'b0;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; exp_data = v_exp[i]; drv_res = v_res[i];
      @(negedge clk);
    end
    in_valid = 1'b0; exp_data = '0; drv_res = '0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done_o[0] && cyc < 40) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; num_vec = '0; exp_data = '0; drv_res = '0;
`ifdef DP_CHK_HALF_EN
    calc_mode = 1'b1;
`endif
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      checks++; if ({busy_o[g], done_o[g], ovf_o[g]} !== 3'b000) begin failures++; $display("FAIL reset_flags inst=%0d got=%b exp=000", g, {busy_o[g], done_o[g], ovf_o[g]}); end
      checks++; if ({chk[g], mis[g], fidx[g], fgot[g], fexp[g]} !== '0) begin failures++; $display("FAIL reset_stats inst=%0d got=%h exp=0", g, {chk[g], mis[g], fidx[g], fgot[g], fexp[g]}); end
    end
    rst = 1'b1;
  endtask

  task automatic test_exact;
    int cyc;
    for (int i = 0; i < 4; i++) begin v_exp[i] = 32'h3F80_0000 + i; v_res[i] = 32'h3F80_0000 + i; end
    start_run(4);
    checks++; if (busy_o[0] !== 1'b1) begin failures++; $display("FAIL t1_busy got=%b exp=1", busy_o[0]); end
    feed(4);
    repeat (3) @(negedge clk);
    checks++; if (chk[0] !== 16'd3) begin failures++; $display("FAIL t1_latency_checked got=%0d exp=3", chk[0]); end
    wait_done(cyc);
    checks++; if (cyc !== 2) begin failures++; $display("FAIL t1_done_timing got=%0d exp=2", cyc); end
    checks++; if (chk[0] !== 16'd4) begin failures++; $display("FAIL t1_checked got=%0d exp=4", chk[0]); end
    checks++; if (mis[0] !== 16'd0) begin failures++; $display("FAIL t1_mismatch got=%0d exp=0", mis[0]); end
    checks++; if (busy_o[0] !== 1'b0) begin failures++; $display("FAIL t1_busy_at_done got=%b exp=0", busy_o[0]); end
    @(negedge clk);
    checks++; if (done_o[0] !== 1'b0) begin failures++; $display("FAIL t1_done_pulse got=%b exp=0", done_o[0]); end
  endtask

  task automatic test_ulp_single;
    int cyc;
    v_exp[0] = 32'h4000_0000; v_res[0] = 32'h4000_0000;
    v_exp[1] = 32'h3F80_0000; v_res[1] = 32'h3F80_0001;
    v_exp[2] = 32'h4040_0000; v_res[2] = 32'h4040_0000;
    start_run(3); feed(3); wait_done(cyc);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL t2_done_timing got=%0d exp=5", cyc); end
    checks++; if (mis[0] !== 16'd1) begin failures++; $display("FAIL t2_mismatch got=%0d exp=1", mis[0]); end
    checks++; if (fidx[0] !== 16'd1) begin failures++; $display("FAIL t2_first_idx got=%0d exp=1", fidx[0]); end
    checks++; if (fgot[0] !== 32'h3F80_0001) begin failures++; $display("FAIL t2_first_got got=%h exp=3f800001", fgot[0]); end
    checks++; if (fexp[0] !== 32'h3F80_0000) begin failures++; $display("FAIL t2_first_exp got=%h exp=3f800000", fexp[0]); end
    checks++; if (mis[1] !== 16'd0) begin failures++; $display("FAIL t2_tol1_mismatch got=%0d exp=0", mis[1]); end
    checks++; if (chk[1] !== 16'd3) begin failures++; $display("FAIL t2_tol1_checked got=%0d exp=3", chk[1]); end
  endtask

  task automatic test_special;
    int cyc;
    v_exp[0] = 32'h0000_0000; v_res[0] = 32'h8000_0000;
    v_exp[1] = 32'h7FC0_0001; v_res[1] = 32'h7FC0_0000;
    v_exp[2] = 32'h3F80_0000; v_res[2] = 32'h3F80_0001;
    v_exp[3] = 32'h3F80_0000; v_res[3] = 32'h3F80_0002;
    v_exp[4] = 32'h7F7F_FFFF; v_res[4] = 32'h7F80_0000;
    start_run(5); feed(5); wait_done(cyc);
    checks++; if (mis[0] !== 16'd3) begin failures++; $display("FAIL t3_tol0_mismatch got=%0d exp=3", mis[0]); end
    checks++; if (fidx[0] !== 16'd2) begin failures++; $display("FAIL t3_tol0_idx got=%0d exp=2", fidx[0]); end
    checks++; if (mis[1] !== 16'd2) begin failures++; $display("FAIL t3_tol1_mismatch got=%0d exp=2", mis[1]); end
    checks++; if (fidx[1] !== 16'd3) begin failures++; $display("FAIL t3_tol1_idx got=%0d exp=3", fidx[1]); end
    checks++; if (fgot[1] !== 32'h3F80_0002) begin failures++; $display("FAIL t3_tol1_got got=%h exp=3f800002", fgot[1]); end
    repeat (3) @(negedge clk);
    checks++; if (chk[0] !== 16'd5 || mis[0] !== 16'd3) begin failures++; $display("FAIL t3_hold got=%0d/%0d exp=5/3", chk[0], mis[0]); end
  endtask

  task automatic test_zero_vec;
    int busy_seen = 0;
    start_run(0);
    checks++; if (done_o[0] !== 1'b1) begin failures++; $display("FAIL t4_done got=%b exp=1", done_o[0]); end
    checks++; if (chk[0] !== 16'd0 || mis[0] !== 16'd0) begin failures++; $display("FAIL t4_cleared got=%0d/%0d exp=0/0", chk[0], mis[0]); end
    for (int i = 0; i < 10; i++) begin
      if (busy_o[0]) busy_seen++;
      in_valid = (i < 3); exp_data = 32'hDEAD_0000 + i; drv_res = 32'h1234_5678;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (busy_seen !== 0) begin failures++; $display("FAIL t4_busy_seen got=%0d exp=0", busy_seen); end
    checks++; if (done_o[0] !== 1'b0) begin failures++; $display("FAIL t4_done_pulse got=%b exp=0", done_o[0]); end
    checks++; if (chk[0] !== 16'd0 || mis[0] !== 16'd0) begin failures++; $display("FAIL t4_idle_valid got=%0d/%0d exp=0/0", chk[0], mis[0]); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    for (int i = 0; i < 6; i++) begin v_exp[i] = 32'h4100_0000 + i; v_res[i] = 32'h4100_0000 + i; end
    start_run(6); feed(6); wait_done(cyc);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL t5_done_timing got=%0d exp=5", cyc); end
    checks++; if (ovf_o[2] !== 1'b0 || mis[2] !== 16'd0) begin failures++; $display("FAIL t5_depth4 ovf/mis got=%b/%0d exp=0/0", ovf_o[2], mis[2]); end
    checks++; if (chk[2] !== 16'd6) begin failures++; $display("FAIL t5_depth4_checked got=%0d exp=6", chk[2]); end
    checks++; if (ovf_o[3] !== 1'b1) begin failures++; $display("FAIL t5_depth2_ovf got=%b exp=1", ovf_o[3]); end
    checks++; if (mis[3] !== 16'd2 || fidx[3] !== 16'd2) begin failures++; $display("FAIL t5_depth2_mis/idx got=%0d/%0d exp=2/2", mis[3], fidx[3]); end
    checks++; if (fexp[3] !== 32'h0 || fgot[3] !== 32'h4100_0002) begin failures++; $display("FAIL t5_depth2_err got=%h/%h exp=41000002/00000000", fgot[3], fexp[3]); end
    checks++; if (chk[3] !== 16'd6) begin failures++; $display("FAIL t5_depth2_checked got=%0d exp=6", chk[3]); end
    repeat (4) @(negedge clk);
    checks++; if (ovf_o[3] !== 1'b1) begin failures++; $display("FAIL t5_ovf_sticky got=%b exp=1", ovf_o[3]); end
  endtask

  task automatic test_reset_mid_run;
    int cyc, done_seen = 0;
    for (int i = 0; i < 6; i++) begin v_exp[i] = 32'h4200_0000 + i; v_res[i] = 32'h4200_0000 + i; end
    start_run(6);
    checks++; if (ovf_o[3] !== 1'b0) begin failures++; $display("FAIL t6_ovf_cleared got=%b exp=0", ovf_o[3]); end
    feed(1);
    in_valid = 1'b1; exp_data = v_exp[1]; drv_res = v_res[1];
    checks++; if (busy_o[0] !== 1'b1) begin failures++; $display("FAIL t6_busy_before got=%b exp=1", busy_o[0]); end
    #2 rst = 1'b0;
    #1;
    checks++; if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin failures++; $display("FAIL t6_async_reset busy/done got=%b/%b exp=0/0", busy_o[0], done_o[0]); end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (done_o[0]) done_seen++; end
    checks++; if (done_seen !== 0 || chk[0] !== 16'd0) begin failures++; $display("FAIL t6_no_done got=%0d/%0d exp=0/0", done_seen, chk[0]); end
    start_run(2); feed(2); wait_done(cyc);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL t6_rerun_timing got=%0d exp=5", cyc); end
    checks++; if (chk[0] !== 16'd2 || mis[0] !== 16'd0) begin failures++; $display("FAIL t6_rerun got=%0d/%0d exp=2/0", chk[0], mis[0]); end
  endtask

`ifdef DP_CHK_HALF_EN
  task automatic test_half;
    int cyc;
    v_exp[0] = 32'h0000_3C00; v_res[0] = 32'hABCD_3C00;
    v_exp[1] = 32'h0000_3C00; v_res[1] = 32'h0000_3C01;
    v_exp[2] = 32'h0000_7C01; v_res[2] = 32'h1234_7E00;
    calc_mode = 1'b0;
    start_run(3);
    calc_mode = 1'b1;
    feed(3); wait_done(cyc);
    checks++; if (mis[0] !== 16'd1 || fidx[0] !== 16'd1) begin failures++; $display("FAIL th_mis/idx got=%0d/%0d exp=1/1", mis[0], fidx[0]); end
    checks++; if (fgot[0] !== 32'h0000_3C01) begin failures++; $display("FAIL th_got got=%h exp=00003c01", fgot[0]); end
    checks++; if (mis[1] !== 16'd0) begin failures++; $display("FAIL th_tol1_mis got=%0d exp=0", mis[1]); end
  endtask
`endif

  initial begin
    test_reset();
    test_exact();
    test_ulp_single();
    test_special();
    test_zero_vec();
    test_back_to_back();
    test_reset_mid_run();
`ifdef DP_CHK_HALF_EN
    test_half();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
